// File: rtl/harry_square_object.sv
// rtl/harry_square_object.sv - Player sprite: pixel hit-test, frame-stepped motion with gravity, collision freeze and respawn.
module harry_square_object #(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 38,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int X_STEP          = 4,
  parameter int JUMP_SPEED      = 12,
  parameter int GRAVITY         = 1,
  parameter int MAX_FALL        = 10,
  parameter int HIT_FRAMES      = 30,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        moveLeft,
  input  logic        moveRight,
  input  logic        jump,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  state
);

  localparam int CW = $clog2(HIT_FRAMES + 1);

  localparam logic        [11:0] OBJ_W   = 12'(OBJECT_WIDTH_X);
  localparam logic        [11:0] OBJ_H   = 12'(OBJECT_HEIGHT_Y);
  localparam logic        [10:0] INIT_X  = 11'(INITIAL_X);
  localparam logic        [10:0] INIT_Y  = 11'(INITIAL_Y);
  localparam logic        [10:0] STEP_X  = 11'(X_STEP);
  localparam logic        [11:0] X_LIMIT = 12'(SCREEN_W - OBJECT_WIDTH_X - X_STEP);
  localparam logic signed [10:0] JUMP_V  = 11'(-JUMP_SPEED);
  localparam logic signed [11:0] GRAV    = 12'(GRAVITY);
  localparam logic signed [11:0] MAXF    = 12'(MAX_FALL);
  localparam logic signed [12:0] Y_MAX   = 13'(SCREEN_H - OBJECT_HEIGHT_Y);
  localparam logic      [CW-1:0] CNT_LD  = CW'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    HIT    = 2'd2
  } state_t;

  state_t             st;
  logic signed [10:0] ySpeed;
  logic [CW-1:0]      hitCnt;
  logic               hitPending;

  assign state = st;

  // Box test against the currently registered position.
  logic [11:0] x_end;
  logic [11:0] y_end;
  logic        inside_c;

  assign x_end    = {1'b0, topLeftX} + OBJ_W;
  assign y_end    = {1'b0, topLeftY} + OBJ_H;
  assign inside_c = (pixelX >= topLeftX) && ({1'b0, pixelX} < x_end) &&
                    (pixelY >= topLeftY) && ({1'b0, pixelY} < y_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= inside_c;
      offsetX         <= inside_c ? (pixelX - topLeftX) : '0;
      offsetY         <= inside_c ? (pixelY - topLeftY) : '0;
    end
  end

  logic [10:0]        x_new;
  logic [10:0]        y_new;
  logic signed [10:0] spd_new;
  logic signed [10:0] spd_raw;
  logic signed [11:0] spd_inc;
  logic signed [12:0] y_sum;

  always_comb begin
    x_new = topLeftX;
    if (moveRight && !moveLeft && ({1'b0, topLeftX} <= X_LIMIT))
      x_new = topLeftX + STEP_X;
    else if (moveLeft && !moveRight && (topLeftX >= STEP_X))
      x_new = topLeftX - STEP_X;

    spd_inc = $signed({ySpeed[10], ySpeed}) + GRAV;
    if (jump)
      spd_raw = JUMP_V;
    else if (spd_inc > MAXF)
      spd_raw = MAXF[10:0];
    else
      spd_raw = spd_inc[10:0];

    // Position uses the freshly updated speed; hitting either limit kills the speed.
    y_sum   = $signed({2'b00, topLeftY}) + $signed({{2{spd_raw[10]}}, spd_raw});
    y_new   = y_sum[10:0];
    spd_new = spd_raw;
    if (y_sum < 13'sd0) begin
      y_new   = '0;
      spd_new = '0;
    end else if (y_sum > Y_MAX) begin
      y_new   = Y_MAX[10:0];
      spd_new = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      topLeftX   <= INIT_X;
      topLeftY   <= INIT_Y;
      ySpeed     <= '0;
      hitCnt     <= '0;
      hitPending <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          topLeftX <= INIT_X;
          topLeftY <= INIT_Y;
          if (startOfFrame && (moveLeft || moveRight || jump))
            st <= FLYING;
        end
        FLYING: begin
          if (startOfFrame) begin
            if (collision || hitPending) begin
              st         <= HIT;
              hitPending <= 1'b0;
              hitCnt     <= CNT_LD;
            end else begin
              topLeftX <= x_new;
              topLeftY <= y_new;
              ySpeed   <= spd_new;
            end
          end else if (collision) begin
            hitPending <= 1'b1;
          end
        end
        HIT: begin
          if (startOfFrame) begin
            if (hitCnt == '0) begin
              st       <= IDLE;
              topLeftX <= INIT_X;
              topLeftY <= INIT_Y;
              ySpeed   <= '0;
            end else begin
              hitCnt <= hitCnt - CW'(1);
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/harry_square_object.md
HARRY_SQUARE_OBJECT -- requirements
Module: harry_square_object

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- OBJECT_WIDTH_X, 64, sprite width in screen pixels (2x-scaled 32-wide bitmap).
- OBJECT_HEIGHT_Y, 38, sprite height in screen pixels (2x-scaled 19-high bitmap).
- INITIAL_X, 280, topLeftX after reset/respawn.
- INITIAL_Y, 185, topLeftY after reset/respawn.
- X_STEP, 4, horizontal pixels per frame.
- JUMP_SPEED, 12, upward speed loaded on jump.
- GRAVITY, 1, speed increment per frame.
- MAX_FALL, 10, downward speed cap.
- HIT_FRAMES, 30, frames frozen after collision.
- SCREEN_W / SCREEN_H, 640 / 480, visible area.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high.
- pixelX, in, 11, current scan X.
- pixelY, in, 11, current scan Y.
- startOfFrame, in, 1, one-cycle pulse per frame.
- moveLeft, in, 1, level key.
- moveRight, in, 1, level key.
- jump, in, 1, level key.
- collision, in, 1, pulse from the collision detector.
- offsetX, out, 11, pixelX minus topLeftX.
- offsetY, out, 11, pixelY minus topLeftY.
- InsideRectangle, out, 1, pixel lies within the sprite box.
- topLeftX, out, 11, current position X.
- topLeftY, out, 11, current position Y.
- state, out, 2, IDLE=0, FLYING=1, HIT=2.

Function
REQ-003 The block SHALL register InsideRectangle, offsetX and offsetY one clock after pixelX/pixelY are sampled.
REQ-004 InsideRectangle SHALL be 1 iff topLeftX<=pixelX<topLeftX+OBJECT_WIDTH_X and topLeftY<=pixelY<topLeftY+OBJECT_HEIGHT_Y.
REQ-005 offsetX/offsetY SHALL be the unsigned differences when inside, and 0 otherwise.
REQ-006 Position, speed and state SHALL change only on cycles where startOfFrame=1, except collision capture (REQ-011).
REQ-007 IDLE: position SHALL be held at INITIAL; the block SHALL go to FLYING at a startOfFrame with any of moveLeft/moveRight/jump=1, and no motion SHALL be applied that frame.
REQ-008 FLYING, horizontal:
- moveRight only and topLeftX+OBJECT_WIDTH_X+X_STEP<=SCREEN_W: topLeftX += X_STEP.
- moveLeft only and topLeftX>=X_STEP: topLeftX -= X_STEP.
- Both keys, neither key, or a move that would cross the edge: topLeftX unchanged.
REQ-009 FLYING, vertical: ySpeed is a signed 11-bit value. On jump=1, ySpeed SHALL be set to -JUMP_SPEED; otherwise ySpeed=min(ySpeed+GRAVITY, MAX_FALL). topLeftY SHALL then add the new ySpeed.
REQ-010 topLeftY SHALL clamp to [0, SCREEN_H-OBJECT_HEIGHT_Y].
- Clamp at the floor: ySpeed=0.
- Clamp at the ceiling: ySpeed=0.
REQ-011 FLYING: collision=1 on any cycle SHALL set a sticky hitPending flag. At the next startOfFrame the block SHALL enter HIT, apply no motion, clear hitPending and load hitCnt=HIT_FRAMES-1.
REQ-012 collision together with startOfFrame in the same cycle SHALL enter HIT directly; no motion SHALL be applied.
REQ-013 HIT: position SHALL be frozen, collision SHALL be ignored, and hitCnt SHALL decrement per startOfFrame.
REQ-014 At the startOfFrame where hitCnt=0, the block SHALL respawn:
- position=INITIAL, ySpeed=0.
- hitCnt SHALL NOT wrap.
- The next state SHALL be IDLE.
REQ-015 State encoding 3 SHALL never occur; if reached, the block SHALL go to IDLE at the next clock.

Reset
REQ-016 reset=1 SHALL immediately force:
- topLeftX=INITIAL_X, topLeftY=INITIAL_Y.
- ySpeed=0, hitCnt=0, hitPending=0.
- state=IDLE.
- InsideRectangle=0, offsetX=0, offsetY=0.
REQ-017 A reset asserted mid-frame or mid-HIT SHALL abandon the current motion and hit count; operation SHALL restart in IDLE after deassertion.
REQ-018 The first startOfFrame after reset deassertion SHALL be evaluated normally; no frame skipping.

Verification
REQ-019 Reset, then pixel (300,200) -> one clock later InsideRectangle=1, offsetX=20, offsetY=15; pixel (344,200) -> InsideRectangle=0, offsets 0.
REQ-020 FLYING at topLeftX=572, moveRight held for 3 frames -> 576, 576, 576; moveLeft+moveRight together -> no change.
REQ-021 FLYING at topLeftY=185, ySpeed=0, jump for one frame, then idle keys -> topLeftY 173, 162, 152; ySpeed -12, -11, -10.
REQ-022 Fall from topLeftY=430 -> clamps to 442 with ySpeed=0 on the same frame.
REQ-023 Collision pulse mid-frame -> HIT at the next startOfFrame; 30 frozen frames; respawn at (280,185) in IDLE. A second collision during HIT is ignored.
REQ-024 Reset asserted in HIT with hitCnt=12 -> IDLE immediately, all outputs at REQ-016 values; collision plus startOfFrame same cycle -> HIT with no motion.
